// File: rtl/snake_ctrl_if.sv
// Bundle of game-control inputs and snake-state outputs for snake_ctrl.
// master: drives start/tick/dir/apple; slave: drives positions/length/status.
interface snake_ctrl_if #(
    parameter int SNAKE_SIZE = 32
);
    localparam int CW = 10;
    localparam int LW = $clog2(SNAKE_SIZE + 1);

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } pt2D;

    logic                   start;
    logic                   tick;
    logic                   dir_valid;
    logic [1:0]             dir_req;
    pt2D                    apple_pos;
    pt2D [SNAKE_SIZE-1:0]   snake_pos;
    logic [LW-1:0]          length;
    logic                   apple_eaten;
    logic                   game_over;
    logic                   busy;

    modport master (
        output start, tick, dir_valid, dir_req, apple_pos,
        input  snake_pos, length, apple_eaten, game_over, busy
    );

    modport slave (
        input  start, tick, dir_valid, dir_req, apple_pos,
        output snake_pos, length, apple_eaten, game_over, busy
    );
endinterface

// File: rtl/snake_ctrl.sv
// Snake game controller: moves the body on tick, handles walls, apples, self-hit.
// Ports: clk, rst (async active-low), bus (snake_ctrl_if.slave).
module snake_ctrl #(
    parameter int SNAKE_SIZE = 32,
    parameter int STEP       = 20,
    parameter int MAX_X      = 780,
    parameter int MAX_Y      = 580
) (
    input  logic          clk,
    input  logic          rst,
    snake_ctrl_if.slave   bus
);
    localparam int CW = 10;
    localparam int LW = $clog2(SNAKE_SIZE + 1);
    localparam int IW = $clog2(SNAKE_SIZE);

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_RIGHT = 2'd1;
    localparam logic [1:0] D_DOWN  = 2'd2;
    localparam logic [1:0] D_LEFT  = 2'd3;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } pt_t;

    typedef enum logic [2:0] {
        IDLE, RUN, SHIFT, CHECK, DEAD
    } state_e;

    state_e        state_q, state_d;
    pt_t           seg_q [SNAKE_SIZE];
    pt_t           seg_d [SNAKE_SIZE];
    logic [LW-1:0] len_q, len_d;
    logic [1:0]    dir_q, dir_d;
    logic [1:0]    pend_q, pend_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          eat_q, eat_d;

    pt_t           nxt;
    logic          wall;
    logic [1:0]    pend_nxt;

    function automatic pt_t init_seg(int i);
        pt_t p;
        if (i < 3) begin
            p.x = CW'(400 - 20 * i);
            p.y = CW'(300);
        end else begin
            p = '1;
        end
        return p;
    endfunction

    // Next head; underflow is caught before subtracting.
    always_comb begin
        nxt  = seg_q[0];
        wall = 1'b0;
        unique case (dir_q)
            D_UP: begin
                if (seg_q[0].y < CW'(STEP)) wall = 1'b1;
                else nxt.y = seg_q[0].y - CW'(STEP);
            end
            D_RIGHT: begin
                nxt.x = seg_q[0].x + CW'(STEP);
                wall  = nxt.x > CW'(MAX_X);
            end
            D_DOWN: begin
                nxt.y = seg_q[0].y + CW'(STEP);
                wall  = nxt.y > CW'(MAX_Y);
            end
            default: begin
                if (seg_q[0].x < CW'(STEP)) wall = 1'b1;
                else nxt.x = seg_q[0].x - CW'(STEP);
            end
        endcase
    end

    // Reversal is judged against the last applied direction.
    assign pend_nxt = (bus.dir_valid && (bus.dir_req != (dir_q ^ 2'd2)))
                    ? bus.dir_req : pend_q;

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        len_d   = len_q;
        dir_d   = dir_q;
        pend_d  = pend_nxt;
        idx_d   = idx_q;
        eat_d   = 1'b0;
        unique case (state_q)
            IDLE, DEAD: begin
                if (bus.start) begin
                    state_d = RUN;
                    len_d   = LW'(3);
                    dir_d   = D_RIGHT;
                    pend_d  = D_RIGHT;
                    for (int i = 0; i < SNAKE_SIZE; i++)
                        seg_d[i] = init_seg(i);
                end
            end
            RUN: begin
                if (bus.tick) begin
                    state_d = SHIFT;
                    dir_d   = pend_nxt;
                end
            end
            SHIFT: begin
                if (wall) begin
                    state_d = DEAD;
                end else begin
                    for (int i = 1; i < SNAKE_SIZE; i++)
                        seg_d[i] = seg_q[i-1];
                    seg_d[0] = nxt;
                    if (nxt == pt_t'(bus.apple_pos)) begin
                        eat_d = 1'b1;
                        if (len_q != LW'(SNAKE_SIZE))
                            len_d = len_q + LW'(1);
                    end
                    idx_d   = IW'(1);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (seg_q[idx_q] == seg_q[0])
                    state_d = DEAD;
                else if (idx_q == IW'(len_q - LW'(1)))
                    state_d = RUN;
                else
                    idx_d = idx_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= LW'(3);
            dir_q   <= D_RIGHT;
            pend_q  <= D_RIGHT;
            idx_q   <= '0;
            eat_q   <= 1'b0;
            for (int i = 0; i < SNAKE_SIZE; i++)
                seg_q[i] <= init_seg(i);
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            eat_q   <= eat_d;
            seg_q   <= seg_d;
        end
    end

    // Inactive segments are parked off-screen.
    for (genvar g = 0; g < SNAKE_SIZE; g++) begin : g_pos
        assign bus.snake_pos[g] = (LW'(g) < len_q) ? seg_q[g] : '1;
    end

    assign bus.length      = len_q;
    assign bus.apple_eaten = eat_q;
    assign bus.game_over   = (state_q == DEAD);
    assign bus.busy        = (state_q == SHIFT) || (state_q == CHECK);
endmodule

// File: doc/snake_ctrl.md
SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 Parameter SNAKE_SIZE, default 32, maximum segment count (4..64).
REQ-002 Parameter STEP, default 20, pixel pitch of one move; MAX_X, default 780, and MAX_Y, default 580, are the largest legal origin coordinates.
REQ-003 Port clk  input  1  single clock for all state.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  level; begins a game from IDLE or DEAD.
REQ-006 Port tick  input  1  one-cycle move strobe.
REQ-007 Port dir_valid  input  1  qualifies dir_req.
REQ-008 Port dir_req  input  2  0=up, 1=right, 2=down, 3=left.
REQ-009 Port apple_pos  input  pt2D  current apple origin.
REQ-010 Port snake_pos  output  pt2D[SNAKE_SIZE-1:0]  segment origins; index 0 is the head.
REQ-011 Port length  output  $clog2(SNAKE_SIZE+1)  active segment count.
REQ-012 Port apple_eaten  output  1  one-cycle pulse when the head lands on the apple.
REQ-013 Port game_over  output  1  high while in DEAD.
REQ-014 Port busy  output  1  high in SHIFT or CHECK.

Function
REQ-015 FSM states are IDLE, RUN, SHIFT, CHECK and DEAD; reset enters IDLE.
REQ-016 IDLE/DEAD -> RUN on start=1; the body is reinitialised on that transition: length=3, dir=right, segments (400,300), (380,300), (360,300).
REQ-017 RUN -> SHIFT on tick=1; ticks arriving in SHIFT, CHECK, IDLE or DEAD are dropped, not queued.
REQ-018 In SHIFT the next head is computed as the head +/- STEP on x or y per the applied direction, using unsigned arithmetic at pt2D field width.
REQ-019 Wall rule: if the next head has x>MAX_X or y>MAX_Y, or it would pass below 0 (underflow detected before the subtract), SHIFT -> DEAD and no segment moves.
REQ-020 Otherwise, in SHIFT every segment i>=1 takes the value of segment i-1 and segment 0 takes the next head, in one cycle; SHIFT -> CHECK.
REQ-021 Apple rule: if the next head equals apple_pos, length increments by 1 in the same SHIFT cycle, saturating at SNAKE_SIZE; apple_eaten pulses in the following cycle.
REQ-022 CHECK scans indices 1..length-1, one comparison per cycle, against the head; a match -> DEAD immediately; scan complete with no match -> RUN.
REQ-023 CHECK takes length-1 cycles; total SHIFT+CHECK latency is length cycles.
REQ-024 Direction: dir_valid=1 in any state loads a pending direction unless dir_req is the reverse of the last applied direction, in which case the request is ignored.
REQ-025 The pending direction is applied at SHIFT entry; the last request before SHIFT wins; a request in the same cycle as tick is honoured.
REQ-026 Segments with index >= length drive x and y all-ones (off-screen) on snake_pos, regardless of their stored value.
REQ-027 Growth: the segment newly activated by a length increment shows the value shifted into it, which is the previous tail position.
REQ-028 In DEAD, positions and length hold until start.
REQ-029 If start is asserted while in RUN, SHIFT or CHECK, it has no effect.

Reset
REQ-030 rst=0 asynchronously forces state=IDLE, length=3, dir=right, pending=right, and the initial segments of REQ-016.
REQ-031 During reset, apple_eaten=0, game_over=0 and busy=0.
REQ-032 Reset asserted mid-SHIFT or mid-CHECK aborts the operation with no partial update visible after release.
REQ-033 Outputs are valid from the first clock edge after reset deasserts.

Verification
REQ-034 Scenario: reset, start, one tick -> head (420,300), tail (380,300), busy high for 3 cycles, then RUN.
REQ-035 Scenario: apple_pos=(420,300), tick -> length 4 the cycle after SHIFT, apple_eaten a single pulse, new tail (360,300).
REQ-036 Scenario: dir_req=left while moving right -> ignored; dir_req=up then tick -> head y decreases by 20.
REQ-037 Scenario: head at x=780 moving right, tick -> DEAD, game_over=1, positions unchanged; start -> reinitialised state of REQ-016.
REQ-038 Scenario: length 5, sequence up/left/down, ticks -> head meets segment 4, DEAD within length-1 CHECK cycles.
REQ-039 Scenario: rst pulsed low during CHECK -> IDLE, initial state of REQ-030; tick during busy -> no extra move.
